// File: rtl/pll_reset_sequencer.sv
// Purpose:      supervises the PLL lock and sequences the system reset for logic clocked from it.
// Latency:      sys_rst_n rises SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES+1 edges after locked is first
//               sampled high; it falls SYNC_STAGES+1 edges after locked drops in S_RUN.
// Backpressure: none. The sequencer free-runs on the reference clock and has no handshake.
// Ports:
//   clk        free-running reference clock (not the PLL output)
//   rst_n      asynchronous active-low reset
//   locked     PLL lock indication, asynchronous to clk
//   pll_reset  active-high reset to the PLL
//   sys_rst_n  active-low system reset (asserted asynchronously, released synchronously)
//   run_en     enable for downstream counters, mirrors sys_rst_n
//   state      current FSM state code, for LEDs
//   loss_count saturating count of lock losses seen while running
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int LOSS_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked,
  output logic                  pll_reset,
  output logic                  sys_rst_n,
  output logic                  run_en,
  output logic [2:0]            state,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  // One shared timer sized for the longest interval it ever has to count.
  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] PLL_LAST    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state_q;
  state_t                 state_nxt;
  logic [TW-1:0]          timer_q;

  // Plain flop chain; lock_s is the only version of locked the FSM ever looks at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Lock loss is always checked before completion, so a drop on the last
  // STABLE/HOLD cycle still falls back to S_WAIT. In S_WAIT a lock that
  // arrives on the timeout cycle beats the re-pulse.
  function automatic state_t next_state(input state_t cur, input logic [TW-1:0] tmr,
                                        input logic lk);
    state_t nxt;
    nxt = S_PLLRST;
    case (cur)
      S_PLLRST: nxt = (tmr == PLL_LAST) ? S_WAIT : S_PLLRST;
      S_WAIT: begin
        if (lk)                        nxt = S_STABLE;
        else if (tmr == TIMEOUT_LAST)  nxt = S_PLLRST;
        else                           nxt = S_WAIT;
      end
      S_STABLE: begin
        if (!lk)                       nxt = S_WAIT;
        else if (tmr == STABLE_LAST)   nxt = S_HOLD;
        else                           nxt = S_STABLE;
      end
      S_HOLD: begin
        if (!lk)                       nxt = S_WAIT;
        else if (tmr == HOLD_LAST)     nxt = S_RUN;
        else                           nxt = S_HOLD;
      end
      S_RUN:    nxt = lk ? S_RUN : S_WAIT;
      default:  nxt = S_PLLRST;
    endcase
    return nxt;
  endfunction

  assign state_nxt = next_state(state_q, timer_q, lock_s);

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_PLLRST;
      timer_q    <= '0;
      pll_reset  <= 1'b1;
      sys_rst_n  <= 1'b0;
      run_en     <= 1'b0;
      loss_count <= '0;
    end else begin
      state_q   <= state_nxt;
      pll_reset <= (state_nxt == S_PLLRST);
      sys_rst_n <= (state_nxt == S_RUN);
      run_en    <= (state_nxt == S_RUN);

      // Timer restarts on every state change; it is frozen in S_RUN where
      // nothing is being timed, so it never wraps.
      if (state_nxt != state_q) begin
        timer_q <= '0;
      end else if (state_q != S_RUN) begin
        timer_q <= timer_q + TW'(1);
      end

      if ((state_q == S_RUN) && !lock_s && (loss_count != {LOSS_CNT_W{1'b1}})) begin
        loss_count <= loss_count + LOSS_CNT_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule
